// File: rtl/tmds_pkg.sv
// Shared TMDS types, control tokens and helpers for the DVI encoder.
package tmds_pkg;

  typedef logic [9:0]        tmds_sym_t;
  typedef logic signed [4:0] tmds_disp_t;

  localparam tmds_sym_t TokCtl00 = 10'h354;
  localparam tmds_sym_t TokCtl01 = 10'h0AB;
  localparam tmds_sym_t TokCtl10 = 10'h154;
  localparam tmds_sym_t TokCtl11 = 10'h2AB;

  // Number of set bits in a byte (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Control token for {c1,c0}.
  function automatic tmds_sym_t ctl_token(input logic [1:0] c);
    tmds_sym_t t;
    unique case (c)
      2'b00:   t = TokCtl00;
      2'b01:   t = TokCtl01;
      2'b10:   t = TokCtl10;
      default: t = TokCtl11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: stage 1 transition minimisation, stage 2 DC balance or
// control token, with a private running disparity counter.
module tmds_channel import tmds_pkg::*; (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] d_i,
  input  logic [1:0] c_i,
  input  logic       de_i,
  output tmds_sym_t  sym_o
);

  logic [3:0] n1_in;
  logic       use_xnor;
  logic [8:0] qm_d, qm_q;
  logic       de_q;
  logic [1:0] c_q;

  logic [3:0] n1, n0;
  tmds_disp_t n1_s, n0_s;
  tmds_disp_t cnt_d, cnt_q;
  tmds_sym_t  sym_d, sym_q;

  // Stage 1 combinational: choose XOR/XNOR chain to minimise transitions.
  always_comb begin
    n1_in    = popcount8(d_i);
    use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !d_i[0]);
    qm_d     = 9'd0;
    qm_d[0]  = d_i[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d_i[i]) : (qm_d[i-1] ^ d_i[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  // Stage 1 registers: q_m travels with its de and control pair.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      qm_q <= 9'd0;
      de_q <= 1'b0;
      c_q  <= 2'b00;
    end else begin
      qm_q <= qm_d;
      de_q <= de_i;
      c_q  <= c_i;
    end
  end

  // Stage 2 combinational: DC balance against running disparity, or token.
  always_comb begin
    n1    = popcount8(qm_q[7:0]);
    n0    = 4'd8 - n1;
    n1_s  = tmds_disp_t'({1'b0, n1});
    n0_s  = tmds_disp_t'({1'b0, n0});
    sym_d = ctl_token(c_q);
    cnt_d = 5'sd0;
    if (de_q) begin
      if ((cnt_q == 5'sd0) || (n1 == n0)) begin
        sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? (cnt_q + (n1_s - n0_s)) : (cnt_q + (n0_s - n1_s));
      end else if (((cnt_q > 5'sd0) && (n1 > n0)) || ((cnt_q < 5'sd0) && (n0 > n1))) begin
        sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) + (n0_s - n1_s);
      end else begin
        sym_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + (n1_s - n0_s);
      end
    end
  end

  // Stage 2 registers: output symbol and disparity; reset forces the idle token.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sym_q <= TokCtl00;
      cnt_q <= 5'sd0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder top: applies sync polarity and maps RGB to three channels.
module dvi_tmds_encoder import tmds_pkg::*; #(
  parameter bit SYNC_INVERT = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [23:0] data,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        data_en,
  output logic [9:0]  tmds0,
  output logic [9:0]  tmds1,
  output logic [9:0]  tmds2
);

  logic [1:0] ctl0;

  // Channel 0 carries {vsync,hsync} as {c1,c0}; others send control 00.
  always_comb begin
    ctl0 = {vsync ^ SYNC_INVERT, hsync ^ SYNC_INVERT};
  end

  tmds_channel u_ch0 (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (data[7:0]),
    .c_i    (ctl0),
    .de_i   (data_en),
    .sym_o  (tmds0)
  );

  tmds_channel u_ch1 (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (data[15:8]),
    .c_i    (2'b00),
    .de_i   (data_en),
    .sym_o  (tmds1)
  );

  tmds_channel u_ch2 (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (data[23:16]),
    .c_i    (2'b00),
    .de_i   (data_en),
    .sym_o  (tmds2)
  );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Scoreboard bench for dvi_tmds_encoder with hand-computed directed vectors.
module tb_dvi_tmds_encoder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [23:0] data = 24'd0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        data_en = 1'b0;
  logic [9:0]  tmds0, tmds1, tmds2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vid = 0;

  typedef struct {
    int         due;
    int         id;
    logic [9:0] e0;
    logic [9:0] e1;
    logic [9:0] e2;
  } exp_t;

  exp_t sb[$];

  dvi_tmds_encoder #(.SYNC_INVERT(1'b0)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .data    (data),
    .hsync   (hsync),
    .vsync   (vsync),
    .data_en (data_en),
    .tmds0   (tmds0),
    .tmds1   (tmds1),
    .tmds2   (tmds2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%03h required=0x%03h", name, act, exp);
    end
  endtask

  // Issue one input cycle and queue its expected symbols (visible two edges later).
  task automatic drive(input logic de, input logic h, input logic v, input logic [23:0] d,
                       input logic [9:0] e2, input logic [9:0] e1, input logic [9:0] e0);
    exp_t e;
    @(negedge clk);
    data_en = de;
    hsync   = h;
    vsync   = v;
    data    = d;
    e.due = cyc + 2;
    e.id  = vid;
    e.e0  = e0;
    e.e1  = e1;
    e.e2  = e2;
    sb.push_back(e);
    vid++;
  endtask

  // Monitor: after every edge, compare any entry due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check($sformatf("v%0d_tmds0", e.id), tmds0, e.e0);
        check($sformatf("v%0d_tmds1", e.id), tmds1, e.e1);
        check($sformatf("v%0d_tmds2", e.id), tmds2, e.e2);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    #23;
    check("rst_tmds0", tmds0, 10'h354);
    check("rst_tmds1", tmds1, 10'h354);
    check("rst_tmds2", tmds2, 10'h354);
    @(negedge clk);
    resetn = 1'b1;

    // Blanking right after release
    repeat (3) drive(1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354);

    // Sync tokens on channel 0
    drive(1'b0, 1'b1, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h0AB);
    drive(1'b0, 1'b0, 1'b1, 24'h000000, 10'h354, 10'h354, 10'h154);
    drive(1'b0, 1'b1, 1'b1, 24'h000000, 10'h354, 10'h354, 10'h2AB);
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354);

    // Zero pixels, syncs high but ignored: cnt -8, 2, -6
    drive(1'b1, 1'b1, 1'b1, 24'h000000, 10'h100, 10'h100, 10'h100);
    drive(1'b1, 1'b1, 1'b1, 24'h000000, 10'h3FF, 10'h3FF, 10'h3FF);
    drive(1'b1, 1'b1, 1'b1, 24'h000000, 10'h100, 10'h100, 10'h100);
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354);

    // All-ones after control
    drive(1'b1, 1'b0, 1'b0, 24'hFFFFFF, 10'h200, 10'h200, 10'h200);
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354);

    // Mixed bytes exercising cases A/B/C with both q_m[8] values
    drive(1'b1, 1'b0, 1'b0, 24'hAA5501, 10'h233, 10'h133, 10'h1FF);
    drive(1'b1, 1'b0, 1'b0, 24'h030F01, 10'h101, 10'h105, 10'h300);
    drive(1'b1, 1'b0, 1'b0, 24'h00FF00, 10'h3FF, 10'h0FF, 10'h100);
    drive(1'b1, 1'b0, 1'b0, 24'hFF00FF, 10'h200, 10'h100, 10'h0FF);

    // de 1->0 token, then de 0->1 starts from cnt=0
    drive(1'b0, 1'b1, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h0AB);
    drive(1'b1, 1'b0, 1'b0, 24'h000000, 10'h100, 10'h100, 10'h100);
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354);

    // Build nonzero disparity, then reset between edges
    drive(1'b1, 1'b0, 1'b0, 24'h010101, 10'h1FF, 10'h1FF, 10'h1FF);
    drive(1'b1, 1'b0, 1'b0, 24'h010101, 10'h300, 10'h300, 10'h300);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_tmds0", tmds0, 10'h354);
    check("midrst_tmds1", tmds1, 10'h354);
    check("midrst_tmds2", tmds2, 10'h354);
    sb.delete();
    data_en = 1'b0;
    hsync   = 1'b0;
    vsync   = 1'b0;
    @(negedge clk);
    check("rsthold_tmds0", tmds0, 10'h354);
    @(negedge clk);
    resetn = 1'b1;

    // After release: token, then first pixel encoded from cnt=0
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354);
    drive(1'b1, 1'b0, 1'b0, 24'h010101, 10'h1FF, 10'h1FF, 10'h1FF);
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354);
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 10'h354, 10'h354, 10'h354);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0 pending", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
